control_unit: RTL and testbench

//  Multicycle Moore/Mealy control FSM that drives the CPU datapath: every mux select,

---
 rtl/ctrl_pkg.sv | 133 +++++++++++++
 rtl/alu_ctrl_decode.sv | 22 ++
 rtl/control_unit.sv | 172 +++++++++++++++++
 tb/tb_control_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, opcode/funct values,
// ALU codes, mux selects, exception causes and the per-state Moore output table.
package ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET     = 5'd0,
        S_FETCH0    = 5'd1,
        S_FETCHW    = 5'd2,
        S_FETCH2    = 5'd3,
        S_DECODE    = 5'd4,
        S_R_EXEC    = 5'd5,
        S_R_WB      = 5'd6,
        S_ADDI_EXEC = 5'd7,
        S_ADDI_WB   = 5'd8,
        S_MEM_ADDR  = 5'd9,
        S_LW_RD     = 5'd10,
        S_LW_W      = 5'd11,
        S_LW_WB     = 5'd12,
        S_SW_WR     = 5'd13,
        S_BRANCH    = 5'd14,
        S_JUMP      = 5'd15,
        S_EXC       = 5'd16
    } state_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ULA_NONE = 3'b000;
    localparam logic [2:0] ULA_ADD  = 3'b001;
    localparam logic [2:0] ULA_SUB  = 3'b010;
    localparam logic [2:0] ULA_AND  = 3'b011;
    localparam logic [2:0] ULA_CMP  = 3'b111;

    localparam logic [2:0] M1_PC     = 3'd0;
    localparam logic [2:0] M1_ALUOUT = 3'd1;
    localparam logic [2:0] M2_RT     = 3'd0;
    localparam logic [2:0] M2_RD     = 3'd1;
    localparam logic [2:0] M3_MEM    = 3'd0;
    localparam logic [2:0] M3_ALUOUT = 3'd1;
    localparam logic [2:0] M4_PC     = 3'd0;
    localparam logic [2:0] M4_A      = 3'd1;
    localparam logic [2:0] M5_B      = 3'd0;
    localparam logic [2:0] M5_IMM    = 3'd1;
    localparam logic [2:0] M5_IMMSH  = 3'd2;
    localparam logic [2:0] M5_FOUR   = 3'd3;
    localparam logic [2:0] M13_ALU   = 3'd0;
    localparam logic [2:0] M13_AOUT  = 3'd1;
    localparam logic [2:0] M13_JUMP  = 3'd2;
    localparam logic [2:0] M13_EXC   = 3'd3;

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_BADOP = 2'b01;
    localparam logic [1:0] EXC_OVF   = 2'b10;

    typedef struct packed {
        logic       pc_w;
        logic [2:0] mux1;
        logic       mem_w;
        logic       ir_w;
        logic [2:0] mux2;
        logic [2:0] mux3;
        logic       reg_w;
        logic       a_w;
        logic       b_w;
        logic [2:0] mux4;
        logic [2:0] mux5;
        logic [2:0] ula;
        logic       aluout_w;
        logic [2:0] mux13;
        logic       epc_w;
    } ctrl_out_t;

    // Moore output table; the branch PC write is added outside since it depends on Igual.
    function automatic ctrl_out_t state_outputs(input state_e st, input logic [2:0] r_ula);
        ctrl_out_t o;
        o = '0;
        case (st)
            S_FETCH0, S_FETCHW: begin
                o.mux1 = M1_PC;  o.mux4 = M4_PC;  o.mux5 = M5_FOUR;  o.ula = ULA_ADD;
            end
            S_FETCH2: begin
                o.ir_w = 1'b1;  o.pc_w = 1'b1;  o.mux13 = M13_ALU;
            end
            S_DECODE: begin
                o.a_w = 1'b1;  o.b_w = 1'b1;  o.mux4 = M4_PC;  o.mux5 = M5_IMMSH;
                o.ula = ULA_ADD;  o.aluout_w = 1'b1;
            end
            S_R_EXEC: begin
                o.mux4 = M4_A;  o.mux5 = M5_B;  o.ula = r_ula;  o.aluout_w = 1'b1;
            end
            S_R_WB: begin
                o.reg_w = 1'b1;  o.mux2 = M2_RD;  o.mux3 = M3_ALUOUT;
            end
            S_ADDI_EXEC, S_MEM_ADDR: begin
                o.mux4 = M4_A;  o.mux5 = M5_IMM;  o.ula = ULA_ADD;  o.aluout_w = 1'b1;
            end
            S_ADDI_WB: begin
                o.reg_w = 1'b1;  o.mux2 = M2_RT;  o.mux3 = M3_ALUOUT;
            end
            S_LW_RD, S_LW_W: begin
                o.mux1 = M1_ALUOUT;
            end
            S_LW_WB: begin
                o.mux1 = M1_ALUOUT;  o.reg_w = 1'b1;  o.mux2 = M2_RT;  o.mux3 = M3_MEM;
            end
            S_SW_WR: begin
                o.mux1 = M1_ALUOUT;  o.mem_w = 1'b1;
            end
            S_BRANCH: begin
                o.mux4 = M4_A;  o.mux5 = M5_B;  o.ula = ULA_CMP;  o.mux13 = M13_AOUT;
            end
            S_JUMP: begin
                o.pc_w = 1'b1;  o.mux13 = M13_JUMP;
            end
            S_EXC: begin
                o.mux4 = M4_PC;  o.mux5 = M5_FOUR;  o.ula = ULA_SUB;  o.epc_w = 1'b1;
                o.pc_w = 1'b1;  o.mux13 = M13_EXC;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational R-type funct decode into the ALU operation code.
module alu_ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] ula_sel_o,
    output logic       valid_funct_o
);

    // funct to ALU code; unsupported functs report invalid with a null op
    always_comb begin
        ula_sel_o     = ULA_NONE;
        valid_funct_o = 1'b0;
        case (funct_i)
            FN_ADD: begin ula_sel_o = ULA_ADD; valid_funct_o = 1'b1; end
            FN_SUB: begin ula_sel_o = ULA_SUB; valid_funct_o = 1'b1; end
            FN_AND: begin ula_sel_o = ULA_AND; valid_funct_o = 1'b1; end
            default: begin ula_sel_o = ULA_NONE; valid_funct_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute and drives every
// datapath select and write enable from registered Moore outputs.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int ST_W     = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic            Overflow,
    input  logic            Igual,
    output logic            PC_w,
    output logic [2:0]      mux1_s,
    output logic            memoria_w,
    output logic            IR_control,
    output logic [2:0]      mux2_s,
    output logic [2:0]      mux3_s,
    output logic            reg_w,
    output logic            a_w,
    output logic            b_w,
    output logic [2:0]      mux4_s,
    output logic [2:0]      mux5_s,
    output logic [2:0]      ula_selector,
    output logic            ALUOut_w,
    output logic [2:0]      mux13_s,
    output logic            epc_w,
    output logic [1:0]      exc_cause,
    output logic [ST_W-1:0] state_out
);

    localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT - 1);

    state_e     state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [1:0] cause_q, cause_d;
    ctrl_out_t  outs_q, outs_d;
    logic [2:0] ula_dec_s;
    logic       valid_funct_s;
    logic       r_arith_s;
    logic       branch_take_s;

    alu_ctrl_decode u_alu_ctrl_decode (
        .funct_i       (funct),
        .ula_sel_o     (ula_dec_s),
        .valid_funct_o (valid_funct_s)
    );

    assign r_arith_s = (ula_dec_s == ULA_ADD) || (ula_dec_s == ULA_SUB);

    // Next-state, wait-counter and exception-cause logic; outputs follow the next state
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cause_d = cause_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH0;
            S_FETCH0: begin
                wait_d = '0;
                if (MEM_WAIT == 0) state_d = S_FETCH2;
                else               state_d = S_FETCHW;
            end
            S_FETCHW: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = S_FETCH2;
                end else begin
                    wait_d  = wait_q + CW'(1);
                end
            end
            S_FETCH2: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R: begin
                        if (valid_funct_s) begin
                            state_d = S_R_EXEC;
                        end else begin
                            state_d = S_EXC;
                            cause_d = EXC_BADOP;
                        end
                    end
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_EXC;
                        cause_d = EXC_BADOP;
                    end
                endcase
            end
            S_R_EXEC: begin
                if (Overflow && r_arith_s) begin
                    state_d = S_EXC;
                    cause_d = EXC_OVF;
                end else begin
                    state_d = S_R_WB;
                end
            end
            S_ADDI_EXEC: begin
                if (Overflow) begin
                    state_d = S_EXC;
                    cause_d = EXC_OVF;
                end else begin
                    state_d = S_ADDI_WB;
                end
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW) state_d = S_LW_RD;
                else                 state_d = S_SW_WR;
            end
            S_LW_RD: begin
                wait_d = '0;
                if (MEM_WAIT == 0) state_d = S_LW_WB;
                else               state_d = S_LW_W;
            end
            S_LW_W: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = S_LW_WB;
                end else begin
                    wait_d  = wait_q + CW'(1);
                end
            end
            S_R_WB, S_ADDI_WB, S_LW_WB, S_SW_WR, S_BRANCH, S_JUMP, S_EXC:
                state_d = S_FETCH0;
            default: state_d = S_RESET;
        endcase
        outs_d = state_outputs(state_d, ula_dec_s);
    end

    // State, counter, cause and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RESET;
            wait_q  <= '0;
            cause_q <= EXC_NONE;
            outs_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            outs_q  <= outs_d;
        end
    end

    // Branch PC write is the only Mealy output: IR holds the opcode, Igual is live
    assign branch_take_s = (state_q == S_BRANCH) &&
                           (((opcode == OP_BEQ) && Igual) || ((opcode == OP_BNE) && !Igual));

    assign PC_w         = outs_q.pc_w | branch_take_s;
    assign mux1_s       = outs_q.mux1;
    assign memoria_w    = outs_q.mem_w;
    assign IR_control   = outs_q.ir_w;
    assign mux2_s       = outs_q.mux2;
    assign mux3_s       = outs_q.mux3;
    assign reg_w        = outs_q.reg_w;
    assign a_w          = outs_q.a_w;
    assign b_w          = outs_q.b_w;
    assign mux4_s       = outs_q.mux4;
    assign mux5_s       = outs_q.mux5;
    assign ula_selector = outs_q.ula;
    assign ALUOut_w     = outs_q.aluout_w;
    assign mux13_s      = outs_q.mux13;
    assign epc_w        = outs_q.epc_w;
    assign exc_cause    = cause_q;
    assign state_out    = ST_W'(state_q);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit (MEM_WAIT=1): walks every instruction class,
// exceptions and a mid-instruction reset, comparing state and all outputs.
module tb_control_unit;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       Overflow, Igual;
    logic       PC_w, memoria_w, IR_control, reg_w, a_w, b_w, ALUOut_w, epc_w;
    logic [2:0] mux1_s, mux2_s, mux3_s, mux4_s, mux5_s, ula_selector, mux13_s;
    logic [1:0] exc_cause;
    logic [4:0] state_out;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [28:0] e_zero, e_fetch, e_f2, e_dec, e_radd, e_rsub, e_rand, e_rwb, e_exc;
    logic [28:0] e_iex, e_iwb, e_lwrd, e_lwwb, e_sw, e_br_t, e_br_n, e_j;

    always #5 clk = ~clk;

    control_unit #(.MEM_WAIT(1), .ST_W(5)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .Overflow(Overflow), .Igual(Igual), .PC_w(PC_w), .mux1_s(mux1_s),
        .memoria_w(memoria_w), .IR_control(IR_control), .mux2_s(mux2_s),
        .mux3_s(mux3_s), .reg_w(reg_w), .a_w(a_w), .b_w(b_w), .mux4_s(mux4_s),
        .mux5_s(mux5_s), .ula_selector(ula_selector), .ALUOut_w(ALUOut_w),
        .mux13_s(mux13_s), .epc_w(epc_w), .exc_cause(exc_cause), .state_out(state_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [28:0] outs_now();
        return {PC_w, mux1_s, memoria_w, IR_control, mux2_s, mux3_s, reg_w, a_w, b_w,
                mux4_s, mux5_s, ula_selector, ALUOut_w, mux13_s, epc_w};
    endfunction

    function automatic logic [28:0] mk(
        input logic pcw, input logic [2:0] m1, input logic mw, input logic ir,
        input logic [2:0] m2, input logic [2:0] m3, input logic rw, input logic aw,
        input logic bw, input logic [2:0] m4, input logic [2:0] m5, input logic [2:0] ula,
        input logic aluw, input logic [2:0] m13, input logic epc);
        return {pcw, m1, mw, ir, m2, m3, rw, aw, bw, m4, m5, ula, aluw, m13, epc};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_st(input string tag, input logic [4:0] st, input logic [28:0] o);
        check_eq({tag, "/state"}, 32'(state_out), 32'(st));
        check_eq({tag, "/outs"}, 32'(outs_now()), 32'(o));
    endtask

    // From FETCH0 through DECODE; the opcode/funct appear once IR is loaded
    task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
        expect_st({tag, ":fetch0"}, 5'd1, e_fetch);
        step();
        expect_st({tag, ":fetchw"}, 5'd2, e_fetch);
        step();
        expect_st({tag, ":fetch2"}, 5'd3, e_f2);
        opcode = op;
        funct  = fn;
        step();
        expect_st({tag, ":decode"}, 5'd4, e_dec);
    endtask

    initial begin
        e_zero  = mk(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        e_fetch = mk(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd3, 3'd1, 1'b0, 3'd0, 1'b0);
        e_f2    = mk(1'b1, 3'd0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        e_dec   = mk(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd2, 3'd1, 1'b1, 3'd0, 1'b0);
        e_radd  = mk(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 3'd1, 1'b1, 3'd0, 1'b0);
        e_rsub  = mk(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 3'd2, 1'b1, 3'd0, 1'b0);
        e_rand  = mk(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 3'd3, 1'b1, 3'd0, 1'b0);
        e_rwb   = mk(1'b0, 3'd0, 1'b0, 1'b0, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        e_exc   = mk(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd3, 3'd2, 1'b0, 3'd3, 1'b1);
        e_iex   = mk(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd1, 3'd1, 1'b1, 3'd0, 1'b0);
        e_iwb   = mk(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        e_lwrd  = mk(1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        e_lwwb  = mk(1'b0, 3'd1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        e_sw    = mk(1'b0, 3'd1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        e_br_t  = mk(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 3'd7, 1'b0, 3'd1, 1'b0);
        e_br_n  = mk(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 3'd7, 1'b0, 3'd1, 1'b0);
        e_j     = mk(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd2, 1'b0);

        reset = 1'b0; opcode = 6'h00; funct = 6'h00; Overflow = 1'b0; Igual = 1'b0;
        @(negedge clk);
        step();
        expect_st("reset", 5'd0, e_zero);
        check_eq("reset/cause", 32'(exc_cause), 32'd0);
        reset = 1'b1;
        step();

        fetch_decode("add", 6'h00, 6'h20);
        step(); expect_st("add:rexec", 5'd5, e_radd);
        step(); expect_st("add:rwb", 5'd6, e_rwb);
        check_eq("add/cause", 32'(exc_cause), 32'd0);
        step();

        fetch_decode("addovf", 6'h00, 6'h20);
        step(); expect_st("addovf:rexec", 5'd5, e_radd);
        Overflow = 1'b1;
        step(); expect_st("addovf:exc", 5'd16, e_exc);
        check_eq("addovf/cause", 32'(exc_cause), 32'd2);
        Overflow = 1'b0;
        step();

        fetch_decode("sub", 6'h00, 6'h22);
        step(); expect_st("sub:rexec", 5'd5, e_rsub);
        step(); expect_st("sub:rwb", 5'd6, e_rwb);
        step();

        fetch_decode("and", 6'h00, 6'h24);
        step(); expect_st("and:rexec", 5'd5, e_rand);
        Overflow = 1'b1;
        step(); expect_st("and:rwb_ignores_ovf", 5'd6, e_rwb);
        Overflow = 1'b0;
        step();

        fetch_decode("addi", 6'h08, 6'h00);
        step(); expect_st("addi:exec", 5'd7, e_iex);
        step(); expect_st("addi:wb", 5'd8, e_iwb);
        step();

        fetch_decode("lw", 6'h23, 6'h00);
        step(); expect_st("lw:addr", 5'd9, e_iex);
        step(); expect_st("lw:rd", 5'd10, e_lwrd);
        step(); expect_st("lw:wait", 5'd11, e_lwrd);
        step(); expect_st("lw:wb", 5'd12, e_lwwb);
        step();

        fetch_decode("sw", 6'h2B, 6'h00);
        step(); expect_st("sw:addr", 5'd9, e_iex);
        step(); expect_st("sw:wr", 5'd13, e_sw);
        step();

        fetch_decode("beq", 6'h04, 6'h00);
        step();
        Igual = 1'b1; #1;
        expect_st("beq:taken", 5'd14, e_br_t);
        Igual = 1'b0; #1;
        expect_st("beq:nottaken", 5'd14, e_br_n);
        step();

        fetch_decode("bne", 6'h05, 6'h00);
        step();
        Igual = 1'b0; #1;
        expect_st("bne:taken", 5'd14, e_br_t);
        Igual = 1'b1; #1;
        expect_st("bne:nottaken", 5'd14, e_br_n);
        Igual = 1'b0;
        step();

        fetch_decode("j", 6'h02, 6'h00);
        step(); expect_st("j:jump", 5'd15, e_j);
        step();

        fetch_decode("badop", 6'h3F, 6'h00);
        step(); expect_st("badop:exc", 5'd16, e_exc);
        check_eq("badop/cause", 32'(exc_cause), 32'd1);
        step();
        fetch_decode("add2", 6'h00, 6'h20);
        check_eq("add2/cause_held", 32'(exc_cause), 32'd1);
        step(); step();
        expect_st("add2:rwb", 5'd6, e_rwb);
        check_eq("add2/cause_held_wb", 32'(exc_cause), 32'd1);
        step();

        fetch_decode("addiovf", 6'h08, 6'h00);
        step(); expect_st("addiovf:exec", 5'd7, e_iex);
        Overflow = 1'b1;
        step(); expect_st("addiovf:exc", 5'd16, e_exc);
        check_eq("addiovf/cause", 32'(exc_cause), 32'd2);
        Overflow = 1'b0;
        step();

        fetch_decode("badfn", 6'h00, 6'h21);
        step(); expect_st("badfn:exc", 5'd16, e_exc);
        check_eq("badfn/cause", 32'(exc_cause), 32'd1);
        step();

        fetch_decode("lwrst", 6'h23, 6'h00);
        step(); step();
        step(); expect_st("lwrst:wait", 5'd11, e_lwrd);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_st("lwrst:held", 5'd0, e_zero);
            check_eq("lwrst/cause", 32'(exc_cause), 32'd0);
        end
        reset = 1'b1;
        step();
        expect_st("lwrst:release", 5'd1, e_fetch);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
